// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer: power-up init, cursor tracking,
// line/screen wrap and CR/FF control characters.
module lcd_char_writer #(
    parameter int P_POWERUP_CYCLES = 750000,
    parameter int P_E_PULSE_CYCLES = 12,
    parameter int P_CMD_CYCLES     = 2000,
    parameter int P_CLEAR_CYCLES   = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] i_Data,
    input  logic       i_Valid,
    output logic       o_Done,
    output logic       o_LCD_RS,
    output logic       o_LCD_RW,
    output logic       o_LCD_E,
    output logic [7:0] o_LCD_Data,
    output logic       o_LCD_On
);
    localparam int MAX_A = (P_POWERUP_CYCLES > P_E_PULSE_CYCLES) ?
                           P_POWERUP_CYCLES : P_E_PULSE_CYCLES;
    localparam int MAX_B = (P_CMD_CYCLES > P_CLEAR_CYCLES) ?
                           P_CMD_CYCLES : P_CLEAR_CYCLES;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW = $clog2(MAX_ALL + 1);

    // Loads are N-1 so each timed state occupies exactly N clocks.
    localparam logic [CW-1:0] LD_PU  = CW'(P_POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_E   = CW'(P_E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LD_CMD = CW'(P_CMD_CYCLES - 1);
    localparam logic [CW-1:0] LD_CLR = CW'(P_CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_READY,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_FOLLOW
    } state_t;

    typedef enum logic [1:0] {
        K_INIT,
        K_REQ,
        K_FOLLOW
    } kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [5:0]    cur_q, cur_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;
    logic          done_q, done_d;
    logic          is_cr, is_ff;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h01;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    assign is_cr = (i_Data == 8'h0D);
    assign is_ff = (i_Data == 8'h0C);

    // S_INIT and S_FOLLOW double as the one-clock setup phase of their writes.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done_d  = done_q;
        unique case (state_q)
            S_POWERUP: begin
                if (cnt_q == '0) begin
                    state_d = S_INIT;
                    kind_d  = K_INIT;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INIT, S_SETUP, S_FOLLOW: begin
                state_d = S_PULSE;
                cnt_d   = LD_E;
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = (data_q == 8'h01) ? LD_CLR : LD_CMD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (kind_q == K_INIT && idx_q != 2'd3) begin
                    state_d = S_INIT;
                    idx_d   = idx_q + 2'd1;
                    data_d  = init_cmd(idx_q + 2'd1);
                end else if (kind_q == K_REQ && rs_q && cur_q == 6'd16) begin
                    state_d = S_FOLLOW;
                    kind_d  = K_FOLLOW;
                    rs_d    = 1'b0;
                    data_d  = 8'hC0;
                end else if (kind_q == K_REQ && rs_q && cur_q == 6'd32) begin
                    state_d = S_FOLLOW;
                    kind_d  = K_FOLLOW;
                    rs_d    = 1'b0;
                    data_d  = 8'h01;
                    cur_d   = 6'd0;
                end else begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end
            end
            S_READY: begin
                if (i_Valid) begin
                    state_d = S_SETUP;
                    kind_d  = K_REQ;
                    done_d  = 1'b0;
                    unique case (1'b1)
                        is_cr: begin
                            rs_d = 1'b0;
                            if (cur_q < 6'd16) begin
                                data_d = 8'h80;
                                cur_d  = 6'd0;
                            end else begin
                                data_d = 8'hC0;
                                cur_d  = 6'd16;
                            end
                        end
                        is_ff: begin
                            rs_d   = 1'b0;
                            data_d = 8'h01;
                            cur_d  = 6'd0;
                        end
                        default: begin
                            rs_d   = 1'b1;
                            data_d = i_Data;
                            cur_d  = cur_q + 6'd1;
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = LD_PU;
                done_d  = 1'b0;
            end
        endcase
        e_d = (state_d == S_PULSE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_POWERUP;
            kind_q  <= K_INIT;
            cnt_q   <= LD_PU;
            idx_q   <= 2'd0;
            cur_q   <= 6'd0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    assign o_Done     = done_q;
    assign o_LCD_RS   = rs_q;
    assign o_LCD_RW   = 1'b0;
    assign o_LCD_E    = e_q;
    assign o_LCD_Data = data_q;
    assign o_LCD_On   = reset;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Scoreboarded directed bench for lcd_char_writer: init sequence,
// characters, wraps, CR/FF and asynchronous reset mid-write.
module tb_lcd_char_writer;
    localparam int PU  = 20;
    localparam int PE  = 2;
    localparam int PC  = 5;
    localparam int PCL = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_Data = 8'h00;
    logic       i_Valid = 1'b0;
    logic       o_Done, o_LCD_RS, o_LCD_RW, o_LCD_E, o_LCD_On;
    logic [7:0] o_LCD_Data;

    lcd_char_writer #(
        .P_POWERUP_CYCLES(PU),
        .P_E_PULSE_CYCLES(PE),
        .P_CMD_CYCLES    (PC),
        .P_CLEAR_CYCLES  (PCL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_Data    (i_Data),
        .i_Valid   (i_Valid),
        .o_Done    (o_Done),
        .o_LCD_RS  (o_LCD_RS),
        .o_LCD_RW  (o_LCD_RW),
        .o_LCD_E   (o_LCD_E),
        .o_LCD_Data(o_LCD_Data),
        .o_LCD_On  (o_LCD_On)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
        logic [7:0] w;
    } wr_t;

    wr_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cur = 0;
    int   npulse = 0;
    int   hi = 0;
    int   lo = 0;
    int   last_w = 0;
    logic prev_e = 1'b0;
    logic prev_done = 1'b0;
    logic have_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        wr_t x;
        x.rs = rs;
        x.d  = d;
        x.w  = (d == 8'h01) ? 8'(PCL) : 8'(PC);
        exp_q.push_back(x);
    endtask

    // One clock: sample at the falling edge and track E pulses and gaps.
    task automatic tick();
        wr_t x;
        @(negedge clock);
        if (o_LCD_E && !prev_e) begin
            npulse++;
            if (have_prev) chk("gap_to_next", lo - 1, last_w);
            chk("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("wr_rs", o_LCD_RS, x.rs);
                chk("wr_data", o_LCD_Data, x.d);
                last_w = x.w;
            end
            hi = 1;
            have_prev = 1'b1;
        end else if (o_LCD_E) begin
            hi++;
        end
        if (!o_LCD_E && prev_e) begin
            chk("e_width", hi, PE);
            lo = 1;
        end else if (!o_LCD_E) begin
            lo++;
        end
        if (o_Done && !prev_done && have_prev) begin
            chk("gap_to_done", lo - 1, last_w);
            have_prev = 1'b0;
        end
        prev_e    = o_LCD_E;
        prev_done = o_Done;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!o_Done && n < limit) begin
            tick();
            n++;
        end
        chk("done_timeout", o_Done, 1);
    endtask

    task automatic send(input logic [7:0] b, output int lat);
        chk("ready_before_send", o_Done, 1);
        if (b == 8'h0D) begin
            if (cur < 16) begin
                push(1'b0, 8'h80);
                cur = 0;
            end else begin
                push(1'b0, 8'hC0);
                cur = 16;
            end
        end else if (b == 8'h0C) begin
            push(1'b0, 8'h01);
            cur = 0;
        end else begin
            push(1'b1, b);
            cur++;
            if (cur == 16) begin
                push(1'b0, 8'hC0);
            end else if (cur == 32) begin
                push(1'b0, 8'h01);
                cur = 0;
            end
        end
        i_Data  = b;
        i_Valid = 1'b1;
        tick();
        chk("done_fall_on_accept", o_Done, 0);
        i_Valid = 1'b0;
        wait_done(400, lat);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38);
        push(1'b0, 8'h0C);
        push(1'b0, 8'h01);
        push(1'b0, 8'h06);
    endtask

    initial begin
        int lat;
        int n0;
        repeat (3) tick();
        chk("rst_done", o_Done, 0);
        chk("rst_e", o_LCD_E, 0);
        chk("rst_rs", o_LCD_RS, 0);
        chk("rst_rw", o_LCD_RW, 0);
        chk("rst_data", o_LCD_Data, 8'h00);
        chk("rst_on", o_LCD_On, 0);

        push_init();
        n0 = npulse;
        reset = 1'b1;
        wait_done(200, lat);
        chk("init_latency", lat, 57);
        chk("init_pulses", npulse - n0, 4);
        chk("lcd_on", o_LCD_On, 1);
        chk("lcd_rw", o_LCD_RW, 0);

        send(8'h41, lat);
        chk("char_latency", lat, 8);
        send(8'h42, lat);
        send(8'h0D, lat);
        chk("cr_line0_latency", lat, 8);

        n0 = npulse;
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i), lat);
        chk("line_wrap_pulses", npulse - n0, 17);
        chk("line_wrap_latency", lat, 16);

        send(8'h0C, lat);
        chk("ff_latency", lat, 13);
        for (int i = 0; i < 32; i++) send(8'(8'h40 + i), lat);
        chk("screen_wrap_latency", lat, 21);
        n0 = npulse;
        send(8'h5A, lat);
        chk("after_wrap_latency", lat, 8);
        chk("after_wrap_pulses", npulse - n0, 1);

        send(8'h0C, lat);
        for (int i = 0; i < 20; i++) send(8'(8'h61 + i), lat);
        n0 = npulse;
        send(8'h0D, lat);
        chk("cr_line1_latency", lat, 8);
        chk("cr_line1_pulses", npulse - n0, 1);
        send(8'h0C, lat);
        chk("ff2_latency", lat, 13);

        push(1'b1, 8'h5A);
        i_Data  = 8'h5A;
        i_Valid = 1'b1;
        tick();
        i_Valid = 1'b0;
        tick();
        chk("e_in_pulse", o_LCD_E, 1);
        reset = 1'b0;
        #1;
        chk("async_e", o_LCD_E, 0);
        chk("async_done", o_Done, 0);
        chk("async_on", o_LCD_On, 0);
        exp_q.delete();
        prev_e    = 1'b0;
        have_prev = 1'b0;
        cur       = 0;
        repeat (3) tick();
        push_init();
        n0 = npulse;
        reset = 1'b1;
        wait_done(200, lat);
        chk("reinit_latency", lat, 57);
        chk("reinit_pulses", npulse - n0, 4);
        send(8'h58, lat);
        chk("post_reinit_latency", lat, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_char_writer.md
Name: lcd_char_writer

Overview:
- Downstream display stage of the receive path.
- Consumes the byte and valid strobe driven by the MCU controller and writes them to an HD44780-compatible 16x2 character LCD over its 8-bit parallel bus.
- Performs the LCD power-up init sequence, tracks the cursor, handles line wrap, screen wrap and two control characters.
- Reports completion through a level done signal.

Parameters:
P_POWERUP_CYCLES, 750000, clocks of wait after reset release before the first command (15 ms at 50 MHz)
P_E_PULSE_CYCLES, 12, clocks o_LCD_E is held high per write
P_CMD_CYCLES, 2000, clocks of wait after E falls for normal commands and characters
P_CLEAR_CYCLES, 82000, clocks of wait after E falls for the clear command 0x01

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
i_Data  input  8  character byte; sampled on acceptance
i_Valid  input  1  request strobe, level-sensitive
o_Done  output  1  1 = idle and ready; 0 = initialising or busy
o_LCD_RS  output  1  0 = command, 1 = data
o_LCD_RW  output  1  constant 0 (write only)
o_LCD_E  output  1  LCD enable strobe
o_LCD_Data  output  8  LCD data bus
o_LCD_On  output  1  panel power/backlight enable; 1 whenever reset is high

Behaviour:
- One clock domain. All state clears asynchronously when reset=0.
- Reset values:
  - o_Done=0, o_LCD_E=0, o_LCD_RS=0, o_LCD_RW=0, o_LCD_Data=0x00, o_LCD_On=0.
  - Cursor=0, state=S_POWERUP.
- Bus write primitive (one per command or character):
  - S_SETUP: RS and Data driven, E=0, 1 clock.
  - S_PULSE: E=1 for P_E_PULSE_CYCLES.
  - S_WAIT: E=0 for P_CMD_CYCLES, or P_CLEAR_CYCLES when Data=0x01.
  - RS and Data stay stable from S_SETUP until the next S_SETUP.
- Wait counter width: ceil(log2(max parameter+1)) bits. No wrap; loads on entry to each timed state and counts down to 0.
- States: S_POWERUP, S_INIT, S_READY, S_SETUP, S_PULSE, S_WAIT, S_FOLLOW.
- S_POWERUP: waits P_POWERUP_CYCLES, then -> S_INIT.
- S_INIT: issues in order 0x38, 0x0C, 0x01, 0x06, all RS=0. After the last wait: o_Done=1, -> S_READY.
- S_READY acceptance:
  - i_Valid=1 latches i_Data; o_Done goes 0 on the same edge.
  - i_Valid is ignored in every other state.
  - The requester deasserts i_Valid after seeing o_Done=0. i_Valid still high when S_READY is re-entered counts as a new request.
- Accepted byte handling:
  - 0x0D (CR): command 0x80 if cursor<16, else 0xC0. Cursor set to 0 or 16 respectively.
  - 0x0C (FF): command 0x01. Cursor=0.
  - Any other byte: data write, RS=1, then cursor+1.
- S_FOLLOW (after a data write):
  - Cursor==16: command 0xC0.
  - Cursor==32: command 0x01, cursor=0.
  - Otherwise no follow-up.
  - Then o_Done=1, -> S_READY.
- Cursor is a 5-bit value in range 0..31 at rest. A value of 32 exists only transiently in S_FOLLOW, so hold it in a 6-bit register or an explicit wrap flag.
- o_Done rises on the clock edge after the final wait of a request completes. It never pulses high mid-request, including between a character and its follow-up command.
- Reset mid-operation: E drops to 0 immediately (asynchronously) and the full power-up and init sequence replays after release.

Test Plan:
Use P_POWERUP_CYCLES=20, P_E_PULSE_CYCLES=2, P_CMD_CYCLES=5, P_CLEAR_CYCLES=10.
1. Release reset, i_Valid=0 -> four E pulses, each 2 clocks wide, RS=0, Data 0x38, 0x0C, 0x01, 0x06 in order. Gap after the 0x01 pulse is 10 clocks. o_Done rises 57 clocks after release.
2. After init, i_Data=0x41 with i_Valid high for 1 clock -> o_Done=0 next edge. One E pulse with RS=1, Data=0x41. o_Done returns to 1 exactly 8 clocks after it fell.
3. Send 16 bytes 0x30..0x3F -> after the 16th data pulse, a command pulse RS=0, Data=0xC0 precedes o_Done=1. Total of 17 E pulses.
4. Send 32 bytes -> after the 32nd, command 0x01 with a 10-clock wait. Next byte 0x5A is written with no address command first (cursor 0).
5. Cursor at 20, send 0x0D -> single command 0xC0, no RS=1 pulse, cursor 16. Then send 0x0C -> command 0x01, cursor 0.
6. Assert reset low during S_PULSE of a character -> o_LCD_E=0 and o_Done=0 without waiting for a clock edge. After release, the scenario 1 sequence repeats exactly.
